// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : exe_pkg
// Description : Shared encodings for the execute stage (ALU ops, mul/div ops,
//               mul/div FSM states, default iteration count).
// Revision    : 1.0 - initial release
// ============================================================================
package exe_pkg;

    localparam int MD_ITER_DEFAULT = 32;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0101;
    localparam logic [3:0] ALU_XOR = 4'b0010;
    localparam logic [3:0] ALU_LUI = 4'b0110;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0111;
    localparam logic [3:0] ALU_SRA = 4'b1111;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MFHI  = 3'd5;
    localparam logic [2:0] MD_MFLO  = 3'd6;
    localparam logic [2:0] MD_NOP7  = 3'd7;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_FIX  = 2'd2
    } md_state_e;

    function automatic logic is_md_start(input logic [2:0] mdop);
        return (mdop == MD_MULT) || (mdop == MD_MULTU) ||
               (mdop == MD_DIV)  || (mdop == MD_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_unit.sv
`default_nettype none
// ============================================================================
// Module      : md_unit
// Description : Iterative multiply/divide unit owning HI/LO; one shift-add or
//               restoring-subtract step per cycle, sign fix-up in a final cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module md_unit
    import exe_pkg::*;
#(
    parameter int MD_ITER = MD_ITER_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int               CNT_W    = $clog2(MD_ITER + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_ITER - 1);

    md_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [63:0]      acc_q, acc_d;
    logic [31:0]      opnd_q, opnd_d;
    logic [31:0]      araw_q, araw_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;
    logic [2:0]       op_q, op_d;
    logic             aneg_q, aneg_d;
    logic             bneg_q, bneg_d;
    logic             bzero_q, bzero_d;

    logic        start_signed;
    logic        q_signed;
    logic        q_mul;
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [32:0] div_trial;
    logic [63:0] div_next;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    assign start_signed = (op == MD_MULT) || (op == MD_DIV);
    assign q_signed     = (op_q == MD_MULT) || (op_q == MD_DIV);
    assign q_mul        = (op_q == MD_MULT) || (op_q == MD_MULTU);

    // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign mul_sum   = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    assign mul_next  = {mul_sum, acc_q[31:1]};
    assign div_trial = acc_q[63:31] - {1'b0, opnd_q};
    assign div_next  = div_trial[32] ? {acc_q[62:0], 1'b0}
                                     : {div_trial[31:0], acc_q[30:0], 1'b1};

    assign prod_fix = (q_signed && (aneg_q ^ bneg_q)) ? -acc_q : acc_q;
    assign quo_fix  = (q_signed && (aneg_q ^ bneg_q)) ? -acc_q[31:0] : acc_q[31:0];
    assign rem_fix  = (q_signed && aneg_q) ? -acc_q[63:32] : acc_q[63:32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        araw_d  = araw_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        op_d    = op_q;
        aneg_d  = aneg_q;
        bneg_d  = bneg_q;
        bzero_d = bzero_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    state_d = MD_RUN;
                    cnt_d   = '0;
                    op_d    = op;
                    aneg_d  = start_signed && a[31];
                    bneg_d  = start_signed && b[31];
                    bzero_d = (b == 32'd0);
                    araw_d  = a;
                    acc_d   = {32'd0, (start_signed && a[31]) ? -a : a};
                    opnd_d  = (start_signed && b[31]) ? -b : b;
                end
            end
            MD_RUN: begin
                acc_d = q_mul ? mul_next : div_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = MD_FIX;
                end
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                if (q_mul) begin
                    {hi_d, lo_d} = prod_fix;
                end else if (bzero_q) begin
                    hi_d = araw_q;
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = rem_fix;
                    lo_d = quo_fix;
                end
            end
            default: state_d = MD_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            opnd_q  <= '0;
            araw_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            op_q    <= MD_NONE;
            aneg_q  <= 1'b0;
            bneg_q  <= 1'b0;
            bzero_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            araw_q  <= araw_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            op_q    <= op_d;
            aneg_q  <= aneg_d;
            bneg_q  <= bneg_d;
            bzero_q <= bzero_d;
        end
    end

    assign busy = (state_q != MD_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
`default_nettype wire

// File: rtl/pipe_stage_exe_md.sv
`default_nettype none
// ============================================================================
// Module      : pipe_stage_exe_md
// Description : Execute stage - single-cycle ALU, HI/LO read mux and the stall
//               request for instructions that depend on the mul/div unit.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_stage_exe_md
    import exe_pkg::*;
#(
    parameter int MD_ITER = MD_ITER_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        EXE_valid,
    input  logic [3:0]  EXE_aluc,
    input  logic [2:0]  EXE_mdop,
    input  logic [31:0] EXE_a,
    input  logic [31:0] EXE_b,
    output logic [31:0] EXE_alu,
    output logic        EXE_stall,
    output logic        md_busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [31:0] alu_res;
    logic        md_start;
    logic        md_dep;

    always_comb begin
        alu_res = EXE_a + EXE_b;
        case (EXE_aluc[2:0])
            3'b000: alu_res = EXE_a + EXE_b;
            3'b100: alu_res = EXE_a - EXE_b;
            3'b001: alu_res = EXE_a & EXE_b;
            3'b101: alu_res = EXE_a | EXE_b;
            3'b010: alu_res = EXE_a ^ EXE_b;
            3'b110: alu_res = {EXE_b[15:0], 16'h0000};
            3'b011: alu_res = EXE_b << EXE_a[4:0];
            3'b111: alu_res = EXE_aluc[3] ? 32'($signed(EXE_b) >>> EXE_a[4:0])
                                          : (EXE_b >> EXE_a[4:0]);
            default: alu_res = EXE_a + EXE_b;
        endcase
    end

    // Bubbles never start or stall; a stalled mult/div starts once idle.
    assign md_dep    = EXE_valid && (EXE_mdop != MD_NONE) && (EXE_mdop != MD_NOP7);
    assign md_start  = EXE_valid && is_md_start(EXE_mdop) && !md_busy;
    assign EXE_stall = md_dep && md_busy;

    md_unit #(
        .MD_ITER (MD_ITER)
    ) u_md_unit (
        .clock (clock),
        .reset (reset),
        .start (md_start),
        .op    (EXE_mdop),
        .a     (EXE_a),
        .b     (EXE_b),
        .busy  (md_busy),
        .hi    (hi),
        .lo    (lo)
    );

    always_comb begin
        EXE_alu = alu_res;
        if (is_md_start(EXE_mdop)) begin
            EXE_alu = EXE_a + EXE_b;
        end else if (EXE_mdop == MD_MFHI) begin
            EXE_alu = hi;
        end else if (EXE_mdop == MD_MFLO) begin
            EXE_alu = lo;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_exe_md.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_stage_exe_md
// Description : Self-checking bench: directed cases plus random instruction
//               stream compared against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_exe_md;

    localparam int ITER = 32;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        EXE_valid = 1'b0;
    logic [3:0]  EXE_aluc = 4'd0;
    logic [2:0]  EXE_mdop = 3'd0;
    logic [31:0] EXE_a = 32'd0;
    logic [31:0] EXE_b = 32'd0;
    logic [31:0] EXE_alu;
    logic        EXE_stall;
    logic        md_busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: cycles until the unit is idle, and HI/LO
    int          busy_left = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    logic [63:0] m_pend = 64'd0;

    pipe_stage_exe_md #(.MD_ITER(ITER)) dut (
        .clock     (clock),
        .reset     (reset),
        .EXE_valid (EXE_valid),
        .EXE_aluc  (EXE_aluc),
        .EXE_mdop  (EXE_mdop),
        .EXE_a     (EXE_a),
        .EXE_b     (EXE_b),
        .EXE_alu   (EXE_alu),
        .EXE_stall (EXE_stall),
        .md_busy   (md_busy),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] aluc, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [31:0] sb;
        sb = b;
        case (aluc)
            4'b0000, 4'b1000: return a + b;
            4'b0100, 4'b1100: return a - b;
            4'b0001, 4'b1001: return a & b;
            4'b0101, 4'b1101: return a | b;
            4'b0010, 4'b1010: return a ^ b;
            4'b0110, 4'b1110: return b * 32'd65536;
            4'b0011:          return b << a[4:0];
            4'b0111:          return b >> a[4:0];
            4'b1111:          return sb >>> a[4:0];
            default:          return 32'hDEAD_BEEF;
        endcase
    endfunction

    // returns {HI, LO}
    function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
        logic signed [31:0] sa, sb, q, r;
        logic signed [63:0] p;
        sa = a;
        sb = b;
        case (op)
            3'd1: begin
                p = longint'(sa) * longint'(sb);
                return p;
            end
            3'd2: return {32'd0, a} * {32'd0, b};
            3'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            3'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_result(input logic [3:0] aluc, input logic [2:0] mdop,
                                               input logic [31:0] a, input logic [31:0] b);
        if (mdop >= 3'd1 && mdop <= 3'd4) return a + b;
        if (mdop == 3'd5) return m_hi;
        if (mdop == 3'd6) return m_lo;
        return ref_alu(aluc, a, b);
    endfunction

    // Present one instruction (entered ~1 time unit after a rising edge), hold it
    // while the model says it stalls, check every cycle, return stall count.
    task automatic issue(input logic v, input logic [3:0] aluc, input logic [2:0] mdop,
                         input logic [31:0] a, input logic [31:0] b,
                         output int stalls, output logic [31:0] res);
        logic exp_stall;
        logic done;
        logic [63:0] md_r;
        EXE_valid = v;
        EXE_aluc  = aluc;
        EXE_mdop  = mdop;
        EXE_a     = a;
        EXE_b     = b;
        stalls    = 0;
        res       = 32'd0;
        done      = 1'b0;
        for (int cyc = 0; cyc < 100 && !done; cyc++) begin
            #1;
            exp_stall = v && (busy_left > 0) && (mdop >= 3'd1) && (mdop <= 3'd6);
            chk("stall", 32'(EXE_stall), 32'(exp_stall));
            chk("busy", 32'(md_busy), 32'(busy_left > 0));
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            if (v && !exp_stall) begin
                res = EXE_alu;
                chk("alu", EXE_alu, ref_result(aluc, mdop, a, b));
            end
            @(posedge clock);
            if (reset) begin
                busy_left = 0;
                m_hi = 32'd0;
                m_lo = 32'd0;
            end else if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    m_hi = m_pend[63:32];
                    m_lo = m_pend[31:0];
                end
            end else if (v && mdop >= 3'd1 && mdop <= 3'd4) begin
                busy_left = ITER + 1;
                md_r = ref_md(mdop, a, b);
                m_pend = md_r;
            end
            #1;
            if (!exp_stall) done = 1'b1;
            else stalls++;
        end
        chk("stall_bound", 32'(done), 32'd1);
    endtask

    logic [3:0] aluc_tab [9] = '{4'b0000, 4'b0100, 4'b0001, 4'b0101, 4'b0010,
                                 4'b0110, 4'b0011, 4'b0111, 4'b1111};

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return $urandom_range(0, 40);
            4: return 32'(-$urandom_range(1, 40));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int s;
        logic [31:0] r;
        logic [63:0] e;
        logic [31:0] a2, b2;

        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // reset state
        chk("rst_busy", 32'(md_busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        issue(1'b1, 4'b0000, 3'd5, 32'd0, 32'd0, s, r);
        chk("rst_mfhi_stall", 32'(s), 32'd0);

        // ALU
        issue(1'b1, 4'b0000, 3'd0, 32'd7, 32'd5, s, r);
        chk("add", r, 32'h0000_000C);
        issue(1'b1, 4'b0100, 3'd0, 32'd5, 32'd7, s, r);
        chk("sub", r, 32'hFFFF_FFFE);
        issue(1'b1, 4'b1111, 3'd0, 32'd4, 32'h8000_0000, s, r);
        chk("sra", r, 32'hF800_0000);
        issue(1'b1, 4'b0110, 3'd0, 32'd0, 32'h0000_1234, s, r);
        chk("lui", r, 32'h1234_0000);

        // multu then mfhi / mflo
        issue(1'b1, 4'b0000, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, s, r);
        chk("multu_stall", 32'(s), 32'd0);
        issue(1'b1, 4'b0000, 3'd5, 32'd0, 32'd0, s, r);
        chk("mfhi_stall_cycles", 32'(s), 32'd33);
        chk("multu_hi", r, 32'hFFFF_FFFE);
        issue(1'b1, 4'b0000, 3'd6, 32'd0, 32'd0, s, r);
        chk("mflo_stall", 32'(s), 32'd0);
        chk("multu_lo", r, 32'h0000_0001);

        // signed divide and multiply
        issue(1'b1, 4'b0000, 3'd3, 32'hFFFF_FFF9, 32'd2, s, r);
        issue(1'b1, 4'b0000, 3'd5, 32'd0, 32'd0, s, r);
        chk("div_hi", r, 32'hFFFF_FFFF);
        issue(1'b1, 4'b0000, 3'd6, 32'd0, 32'd0, s, r);
        chk("div_lo", r, 32'hFFFF_FFFD);
        issue(1'b1, 4'b0000, 3'd1, 32'hFFFF_FFFD, 32'd4, s, r);
        issue(1'b1, 4'b0000, 3'd5, 32'd0, 32'd0, s, r);
        chk("mult_hi", r, 32'hFFFF_FFFF);
        issue(1'b1, 4'b0000, 3'd6, 32'd0, 32'd0, s, r);
        chk("mult_lo", r, 32'hFFFF_FFF4);

        // corner cases
        issue(1'b1, 4'b0000, 3'd4, 32'd5, 32'd0, s, r);
        issue(1'b1, 4'b0000, 3'd6, 32'd0, 32'd0, s, r);
        chk("divu0_lo", r, 32'hFFFF_FFFF);
        issue(1'b1, 4'b0000, 3'd5, 32'd0, 32'd0, s, r);
        chk("divu0_hi", r, 32'd5);
        issue(1'b1, 4'b0000, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, s, r);
        issue(1'b1, 4'b0000, 3'd6, 32'd0, 32'd0, s, r);
        chk("divovf_lo", r, 32'h8000_0000);
        issue(1'b1, 4'b0000, 3'd5, 32'd0, 32'd0, s, r);
        chk("divovf_hi", r, 32'd0);

        // reset during RUN (reset asserted at T+10)
        issue(1'b1, 4'b0000, 3'd2, 32'd123, 32'd456, s, r);
        for (int i = 0; i < 9; i++) issue(1'b1, 4'b0000, 3'd0, 32'(i), 32'd1, s, r);
        reset = 1'b1;
        issue(1'b0, 4'b0000, 3'd0, 32'd0, 32'd0, s, r);
        reset = 1'b0;
        chk("rstrun_busy", 32'(md_busy), 32'd0);
        chk("rstrun_hi", hi, 32'd0);
        chk("rstrun_lo", lo, 32'd0);
        issue(1'b1, 4'b0000, 3'd5, 32'd0, 32'd0, s, r);
        chk("rstrun_stall", 32'(s), 32'd0);

        // back-to-back mult, bubble with mdop=5 while busy
        a2 = 32'hFFFF_0003;
        b2 = 32'h0001_2345;
        issue(1'b1, 4'b0000, 3'd1, 32'd9, 32'd11, s, r);
        issue(1'b1, 4'b0000, 3'd1, a2, b2, s, r);
        chk("b2b_stall_cycles", 32'(s), 32'd33);
        issue(1'b0, 4'b0000, 3'd5, 32'd0, 32'd0, s, r);
        chk("bubble_busy", 32'(md_busy), 32'd1);
        issue(1'b1, 4'b0000, 3'd5, 32'd0, 32'd0, s, r);
        chk("b2b_mfhi_stall", 32'(s), 32'd32);
        e = ref_md(3'd1, a2, b2);
        chk("b2b_hi", r, e[63:32]);

        // random instruction stream
        for (int n = 0; n < 400; n++) begin
            logic v;
            logic [2:0] md;
            v  = ($urandom_range(0, 99) < 85);
            md = ($urandom_range(0, 99) < 55) ? 3'd0 : 3'($urandom_range(1, 7));
            issue(v, aluc_tab[$urandom_range(0, 8)], md, rnd_opnd(), rnd_opnd(), s, r);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
